cape_uart_apb: RTL and testbench
================================

# cape_uart_apb

APB-attached 8N1 UART for the cape connector, one instance per cape UART channel. It sits beside the cape APB control/status slave. Its TXD/TXD_OE drive a cape pin through the P8/P9 pad wrapper's GPIO_OUT/GPIO_OE bits, RXD is taken from GPIO_IN, and IRQ feeds one bit of the cape INT bus. Transmit and receive paths each have a FIFO and a bit-level state machine, timed by a programmable baud divisor.

## Interface
- FIFO_DEPTH, 16, entries per TX and per RX FIFO; power of two, 2..256
- DIV_RESET, 16'd867, reset value of the baud divisor (115200 baud at 100 MHz)
- PCLK  in  1  sole clock, all logic rising-edge
- PRESET  in  1  synchronous, active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write
- PADDR  in  8  byte address, bits [3:2] decoded, others ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data, registered
- PREADY  out  1  constant 1, zero wait states
- RXD  in  1  serial input from pad GPIO_IN, asynchronous
- TXD  out  1  serial output to pad GPIO_OUT, idle high
- TXD_OE  out  1  pad output enable = CTRL.EN
- IRQ  out  1  level interrupt to cape INT bit

## Operation
- Registers:
  - 0x00 DATA
    - Write pushes PWDATA[7:0] to the TX FIFO; a write while full is dropped and sets STATUS.TXOVF.
    - Read pops the RX FIFO and returns {23'b0, valid, byte}; valid=0 when empty, with no pop.
  - 0x04 STATUS (RO except W1C)
    - [0] TXFULL, [1] TXEMPTY, [2] RXFULL, [3] RXEMPTY, [4] TXIDLE.
    - [5] RXOVF (W1C), [6] FRAMEERR (W1C), [7] TXOVF (W1C), [8] PARERR (W1C; reads 0 without parity).
  - 0x08 DIV: [15:0] divisor D; one bit time = D+1 PCLK cycles. A write takes effect at the next bit boundary.
  - 0x0C CTRL: [0] EN, [1] RXIE, [2] TXIE.
- APB: a write commits in the cycle PSEL&PENABLE&PWRITE; a read pop happens in the cycle PSEL&PENABLE&!PWRITE.
- TX FSM, states IDLE→START→DATA(8, LSB first)→[PARITY]→STOP→IDLE:
  - IDLE leaves only if EN=1 and the FIFO is not empty; the head is popped on entry to START.
  - Back-to-back frames have no extra idle bit.
- RX path:
  - RXD passes through a 2-FF synchronizer. A falling edge in IDLE (EN=1) starts a count of (D+1)/2 cycles.
  - If the line is still low at that sample → DATA; otherwise it is a false start → IDLE.
  - Each bit after that is sampled every D+1 cycles.
  - At STOP: if the sample is 0, set FRAMEERR and discard the byte; if the FIFO is full, set RXOVF and drop the byte; otherwise push.
- IRQ = (RXIE & !RXEMPTY) | (TXIE & TXEMPTY) | RXOVF | FRAMEERR | PARERR; registered.
- EN=0 behaviour:
  - Both FSMs abort to IDLE at the next edge and TXD=1.
  - FIFO contents are kept; TX data can be queued but is not sent.
- Simultaneous cases:
  - A push and pop on the same FIFO in the same cycle both happen, and the count is unchanged; this is legal even when full (the pop frees the slot first) or when empty (no push bypass; the pop gives valid=0).
  - A W1C and a set of the same flag in the same cycle: the set wins.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. Full = MSBs differ and LSBs are equal.

## Timing
- Reset values:
  - TXD=1, TXD_OE=0, IRQ=0, PRDATA=0.
  - FIFOs empty, DIV=DIV_RESET, CTRL=0, all sticky flags 0.
  - Reset mid-frame aborts immediately; TXD=1 in the cycle after PRESET is sampled high.
- PRDATA is valid the cycle after the access phase, registered at the PENABLE edge. Software sampling follows standard APB with PREADY=1.
- DATA write to TXD start-bit fall: 2 PCLK cycles when TX is IDLE.
- Frame length: 10·(D+1) cycles, or 11·(D+1) with parity.
- RXD stop-bit mid-sample to RXEMPTY=0: ≤4 cycles (2 synchronizer cycles + 1 push + 1 status).
- IRQ updates 1 cycle after its source flag.

## Configuration
- CAPE_UART_PARITY_EN
  - Defined: CTRL[3] PEN and CTRL[4] ODD exist. With PEN=1, TX inserts a parity bit (even, or odd if ODD=1) before STOP. RX checks it; on mismatch it sets PARERR and still pushes the byte.
  - Undefined: CTRL[4:3] read 0 and ignore writes, PARERR is always 0, and there is no parity state in either FSM.

## Test plan
- **Reset:** PRESET=1 for 2 cycles → TXD=1, TXD_OE=0, IRQ=0, STATUS=0x01A, DIV=867.
- **TX frame:** DIV=9, EN=1, write 0xA5 → TXD shows 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. TXIDLE=1 at 100 cycles.
- **RX loopback:** drive RXD with frame 0x3C at D=9 → DATA read returns 0x13C; a second read returns 0x000.
- **Overflow:**
  - 17 DATA writes with EN=0 → TXFULL=1, TXOVF=1, 16 entries kept.
  - 17 received frames without reads → RXOVF=1, IRQ=1; writing 0x20 to STATUS clears RXOVF.
- **Framing error:** RX frame with stop bit=0 → FRAMEERR=1, RXEMPTY stays 1, IRQ=1.
- **Parity (macro defined):**
  - PEN=1, ODD=0, send 0x01 → parity bit 1.
  - RX frame with wrong parity → PARERR=1 and the byte is still readable.

Source files
------------

// File: rtl/cape_uart_apb.sv
// cape_uart_apb: APB-attached 8N1 UART with TX/RX FIFOs and a programmable
// baud divisor. Define CAPE_UART_PARITY_EN to add the optional parity bit
// (CTRL.PEN / CTRL.ODD, STATUS.PARERR).
module cape_uart_apb #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        RXD,
  output logic        TXD,
  output logic        TXD_OE,
  output logic        IRQ
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef CAPE_UART_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef CAPE_UART_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;

  logic        wr_en, rd_en, sts_w1c;
  logic [1:0]  reg_sel;
  logic [15:0] div_q;
  logic        ctrl_en, ctrl_rxie, ctrl_txie, ctrl_pen, ctrl_odd;
  logic        txovf, rxovf, frameerr, parerr;
  logic [31:0] rd_data;
  logic        unused;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wptr, tx_rptr;
  logic          tx_full, tx_empty, tx_push, tx_pop, txovf_set;
  tx_state_t     tx_state, tx_next;
  logic [15:0]   tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_par, tx_tick, txd_c;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wptr, rx_rptr;
  logic          rx_full, rx_empty, rx_push, rx_pop, rxovf_set;
  rx_state_t     rx_state, rx_next;
  logic [15:0]   rx_cnt, rx_half_load;
  logic [16:0]   rx_half;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_s1, rx_s2, rx_s3, rx_fall, rx_tick;
  logic          rx_done_ok, ferr_set, perr_set;

  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign rd_en   = PSEL & PENABLE & ~PWRITE;
  assign reg_sel = PADDR[3:2];
  assign sts_w1c = wr_en && (reg_sel == 2'd1);
  assign PREADY  = 1'b1;
  assign TXD_OE  = ctrl_en;
  assign unused  = ^{PADDR[7:4], PADDR[1:0], PWDATA[31:16]};

  // FIFO flags; a pop in the same cycle frees the slot for a push when full
  assign tx_empty  = (tx_wptr == tx_rptr);
  assign tx_full   = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign tx_push   = wr_en && (reg_sel == 2'd0) && (!tx_full || tx_pop);
  assign txovf_set = wr_en && (reg_sel == 2'd0) && tx_full && !tx_pop;

  assign rx_empty  = (rx_wptr == rx_rptr);
  assign rx_full   = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
  assign rx_pop    = rd_en && (reg_sel == 2'd0) && !rx_empty;
  assign rx_push   = rx_done_ok && (!rx_full || rx_pop);
  assign rxovf_set = rx_done_ok && rx_full && !rx_pop;

  // FIFO pointers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= PWDATA[7:0];
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
  end

  // Control and divisor registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      div_q     <= DIV_RESET;
      ctrl_en   <= 1'b0;
      ctrl_rxie <= 1'b0;
      ctrl_txie <= 1'b0;
`ifdef CAPE_UART_PARITY_EN
      ctrl_pen  <= 1'b0;
      ctrl_odd  <= 1'b0;
`endif
    end else begin
      if (wr_en && (reg_sel == 2'd2)) div_q <= PWDATA[15:0];
      if (wr_en && (reg_sel == 2'd3)) begin
        ctrl_en   <= PWDATA[0];
        ctrl_rxie <= PWDATA[1];
        ctrl_txie <= PWDATA[2];
`ifdef CAPE_UART_PARITY_EN
        ctrl_pen  <= PWDATA[3];
        ctrl_odd  <= PWDATA[4];
`endif
      end
    end
  end

`ifndef CAPE_UART_PARITY_EN
  assign ctrl_pen = 1'b0;
  assign ctrl_odd = 1'b0;
  assign parerr   = 1'b0;
  assign perr_set = 1'b0;
`endif

  // Sticky error flags; a set in the same cycle as a W1C wins
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      txovf    <= 1'b0;
      rxovf    <= 1'b0;
      frameerr <= 1'b0;
`ifdef CAPE_UART_PARITY_EN
      parerr   <= 1'b0;
`endif
    end else begin
      txovf    <= txovf_set | (txovf & ~(sts_w1c & PWDATA[7]));
      rxovf    <= rxovf_set | (rxovf & ~(sts_w1c & PWDATA[5]));
      frameerr <= ferr_set | (frameerr & ~(sts_w1c & PWDATA[6]));
`ifdef CAPE_UART_PARITY_EN
      parerr   <= perr_set | (parerr & ~(sts_w1c & PWDATA[8]));
`endif
    end
  end

  // TX state register
  always_ff @(posedge PCLK) begin
    if (PRESET) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  assign tx_tick = (tx_cnt == 16'd0);

  // TX next state: IDLE -> START -> DATA x8 -> [PAR] -> STOP, chaining frames
  always_comb begin
    tx_next = tx_state;
    if (!ctrl_en) begin
      tx_next = TX_IDLE;
    end else begin
      case (tx_state)
        TX_IDLE:  if (!tx_empty) tx_next = TX_START;
        TX_START: if (tx_tick) tx_next = TX_DATA;
        TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = ctrl_pen ? tx_state_t'(3'd3) : TX_STOP;
`ifdef CAPE_UART_PARITY_EN
        TX_PAR:   if (tx_tick) tx_next = TX_STOP;
`endif
        TX_STOP:  if (tx_tick) tx_next = tx_empty ? TX_IDLE : TX_START;
        default:  tx_next = TX_IDLE;
      endcase
    end
  end

  // TX outputs: line level and FIFO pop on entry to START
  always_comb begin
    txd_c  = 1'b1;
    tx_pop = 1'b0;
    if (ctrl_en) begin
      case (tx_state)
        TX_START: txd_c = 1'b0;
        TX_DATA:  txd_c = tx_shift[0];
`ifdef CAPE_UART_PARITY_EN
        TX_PAR:   txd_c = tx_par;
`endif
        default:  txd_c = 1'b1;
      endcase
      tx_pop = (tx_next == TX_START) && (tx_state != TX_START);
    end
  end

  // TX bit timer and shift register; divisor is picked up at each bit boundary
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      tx_par   <= 1'b0;
      TXD      <= 1'b1;
    end else begin
      TXD <= txd_c;
      if ((tx_state == TX_IDLE) || tx_tick) tx_cnt <= div_q;
      else                                  tx_cnt <= tx_cnt - 16'd1;
      if (tx_pop) begin
        tx_shift <= tx_mem[tx_rptr[AW-1:0]];
        tx_bit   <= 3'd0;
        tx_par   <= ^tx_mem[tx_rptr[AW-1:0]] ^ ctrl_odd;
      end else if ((tx_state == TX_DATA) && tx_tick) begin
        tx_shift <= tx_shift >> 1;
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  assign rx_fall      = rx_s3 & ~rx_s2;
  assign rx_tick      = (rx_cnt == 16'd0);
  assign rx_half      = (17'(div_q) + 17'd1) >> 1;
  assign rx_half_load = (rx_half == 17'd0) ? 16'd0 : 16'(rx_half - 17'd1);

  // RXD synchronizer plus edge-detect stage
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= RXD;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX state register
  always_ff @(posedge PCLK) begin
    if (PRESET) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // RX next state: half-bit start qualification, then one sample per bit
  always_comb begin
    rx_next = rx_state;
    if (!ctrl_en) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE:  if (rx_fall) rx_next = RX_START;
        RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
        RX_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = ctrl_pen ? rx_state_t'(3'd3) : RX_STOP;
`ifdef CAPE_UART_PARITY_EN
        RX_PAR:   if (rx_tick) rx_next = RX_STOP;
`endif
        RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
        default:  rx_next = RX_IDLE;
      endcase
    end
  end

  // RX outputs: frame completion and error pulses at the sample points
  always_comb begin
    rx_done_ok = 1'b0;
    ferr_set   = 1'b0;
`ifdef CAPE_UART_PARITY_EN
    perr_set   = 1'b0;
`endif
    if (ctrl_en && rx_tick) begin
      case (rx_state)
        RX_STOP: begin
          rx_done_ok = rx_s2;
          ferr_set   = ~rx_s2;
        end
`ifdef CAPE_UART_PARITY_EN
        RX_PAR:  perr_set = ^{rx_shift, rx_s2, ctrl_odd};
`endif
        default: ;
      endcase
    end
  end

  // RX bit timer and shift register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      if (rx_state == RX_IDLE) rx_cnt <= rx_half_load;
      else if (rx_tick)        rx_cnt <= div_q;
      else                     rx_cnt <= rx_cnt - 16'd1;
      if (rx_state == RX_START) begin
        rx_bit <= 3'd0;
      end else if ((rx_state == RX_DATA) && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // Register read mux
  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      2'd0: rd_data = {23'd0, ~rx_empty, rx_empty ? 8'h00 : rx_mem[rx_rptr[AW-1:0]]};
      2'd1: rd_data = {23'd0, parerr, txovf, frameerr, rxovf, (tx_state == TX_IDLE),
                       rx_empty, rx_full, tx_empty, tx_full};
      2'd2: rd_data = {16'd0, div_q};
      default: rd_data = {27'd0, ctrl_odd, ctrl_pen, ctrl_txie, ctrl_rxie, ctrl_en};
    endcase
  end

  // Registered read data and interrupt
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PRDATA <= 32'd0;
      IRQ    <= 1'b0;
    end else begin
      if (rd_en) PRDATA <= rd_data;
      IRQ <= (ctrl_rxie & ~rx_empty) | (ctrl_txie & tx_empty) | rxovf | frameerr | parerr;
    end
  end

endmodule

// File: tb/tb_cape_uart_apb.sv
// tb_cape_uart_apb: directed + randomized checks of cape_uart_apb against a
// queue-based model of the FIFOs and sticky flags.
module tb_cape_uart_apb;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, rxd, txd, txd_oe, irq;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          bitp   = 10;
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_exp[$];
  bit          m_txovf, m_rxovf, m_ferr, m_perr;

  cape_uart_apb #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd867)) dut (
    .PCLK(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
    .RXD(rxd), .TXD(txd), .TXD_OE(txd_oe), .IRQ(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    tick(1);
    penable = 1'b1;
    tick(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    tick(1);
    penable = 1'b1;
    tick(1);
    psel = 1'b0; penable = 1'b0;
    d = prdata;
  endtask

  function automatic logic [31:0] exp_status(input bit txidle);
    logic [31:0] s;
    s    = 32'd0;
    s[0] = (tx_exp.size() == DEPTH);
    s[1] = (tx_exp.size() == 0);
    s[2] = (rx_exp.size() == DEPTH);
    s[3] = (rx_exp.size() == 0);
    s[4] = txidle;
    s[5] = m_rxovf;
    s[6] = m_ferr;
    s[7] = m_txovf;
    s[8] = m_perr;
    return s;
  endfunction

  // Waits for a start bit on TXD, then samples every bit at mid-bit
  task automatic tx_capture(input string tag, input logic [7:0] eb, input bit pp,
                            input bit ep, output int waited);
    logic [7:0] b;
    int n;
    n = 0;
    b = 8'd0;
    while (txd !== 1'b0 && n < 20 * bitp) begin
      tick(1);
      n++;
    end
    waited = n;
    tick(bitp / 2);
    check({tag, " start"}, 32'(txd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(bitp);
      b[i] = txd;
    end
    check({tag, " byte"}, 32'(b), 32'(eb));
    if (pp) begin
      tick(bitp);
      check({tag, " parity"}, 32'(txd), 32'(ep));
    end
    tick(bitp);
    check({tag, " stop"}, 32'(txd), 32'd1);
  endtask

  task automatic rx_send(input logic [7:0] b, input bit stop, input bit pp, input bit par);
    rxd = 1'b0;
    tick(bitp);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(bitp);
    end
    if (pp) begin
      rxd = par;
      tick(bitp);
    end
    rxd = stop;
    tick(bitp);
    rxd = 1'b1;
  endtask

  // Model of a good received frame arriving at the RX FIFO
  task automatic rx_model_push(input logic [7:0] b);
    if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
    else                       m_rxovf = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          w;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'd0; pwdata = 32'd0; rxd = 1'b1;
    m_txovf = 0; m_rxovf = 0; m_ferr = 0; m_perr = 0;
    tick(2);
    rst = 1'b0;

    // Reset state
    check("reset txd", 32'(txd), 32'd1);
    check("reset txd_oe", 32'(txd_oe), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    check("reset prdata", prdata, 32'd0);
    check("pready", 32'(pready), 32'd1);
    apb_read(8'h04, rd); check("reset status", rd, 32'h01A);
    apb_read(8'h08, rd); check("reset div", rd, 32'd867);
    apb_read(8'h0C, rd); check("reset ctrl", rd, 32'd0);
    apb_read(8'h00, rd); check("reset data empty", rd, 32'd0);

    // Single TX frame with start-bit latency
    apb_write(8'h08, 32'd9);
    apb_write(8'h0C, 32'd1);
    check("txd_oe on", 32'(txd_oe), 32'd1);
    apb_write(8'h00, 32'hA5);
    tick(1); check("tx lat cycle1", 32'(txd), 32'd1);
    tick(1); check("tx lat cycle2", 32'(txd), 32'd0);
    tx_capture("tx a5", 8'hA5, 1'b0, 1'b0, w);
    tick(bitp);
    apb_read(8'h04, rd); check("tx idle status", rd, exp_status(1'b1));

    // Back-to-back random frames queued while disabled
    apb_write(8'h0C, 32'd0);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      tx_exp.push_back(b);
      apb_write(8'h00, 32'(b));
    end
    apb_read(8'h04, rd); check("tx queued status", rd, exp_status(1'b1));
    apb_write(8'h0C, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tx_capture("tx b2b", tx_exp.pop_front(), 1'b0, 1'b0, w);
      if (i > 0) check("tx b2b gap", 32'(w), 32'(bitp - bitp / 2));
    end

    // TX overflow: 17 writes while disabled, 16 kept
    apb_write(8'h0C, 32'd0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (tx_exp.size() < DEPTH) tx_exp.push_back(b);
      else                       m_txovf = 1'b1;
      apb_write(8'h00, 32'(b));
    end
    apb_read(8'h04, rd); check("tx overflow status", rd, exp_status(1'b1));
    apb_write(8'h0C, 32'd1);
    for (int i = 0; i < DEPTH; i++) tx_capture("tx drain", tx_exp.pop_front(), 1'b0, 1'b0, w);
    tick(bitp);
    apb_read(8'h04, rd); check("tx drained status", rd, exp_status(1'b1));
    apb_write(8'h04, 32'h80); m_txovf = 1'b0;
    apb_read(8'h04, rd); check("txovf cleared", rd, exp_status(1'b1));

    // RX loopback of 0x3C, then random frames
    rx_send(8'h3C, 1'b1, 1'b0, 1'b0);
    tick(2);
    apb_read(8'h00, rd); check("rx 3c", rd, 32'h13C);
    apb_read(8'h00, rd); check("rx empty read", rd, 32'h000);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      rx_model_push(b);
      rx_send(b, 1'b1, 1'b0, 1'b0);
    end
    tick(2);
    apb_read(8'h04, rd); check("rx pending status", rd, exp_status(1'b1));
    while (rx_exp.size() > 0) begin
      apb_read(8'h00, rd); check("rx random", rd, {23'd0, 1'b1, rx_exp.pop_front()});
    end

    // RX interrupt enable
    apb_write(8'h0C, 32'd3);
    tick(2); check("irq rxie empty", 32'(irq), 32'd0);
    b = 8'($urandom);
    rx_send(b, 1'b1, 1'b0, 1'b0);
    tick(2); check("irq rxie data", 32'(irq), 32'd1);
    apb_read(8'h00, rd); check("rx irq byte", rd, {23'd0, 1'b1, b});
    tick(2); check("irq rxie cleared", 32'(irq), 32'd0);

    // TX interrupt enable with empty TX FIFO
    apb_write(8'h0C, 32'd5);
    tick(2); check("irq txie", 32'(irq), 32'd1);
    apb_write(8'h0C, 32'd1);
    tick(2); check("irq txie off", 32'(irq), 32'd0);

    // RX overflow: 17 frames without reads
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      rx_model_push(b);
      rx_send(b, 1'b1, 1'b0, 1'b0);
    end
    tick(2);
    check("irq rxovf", 32'(irq), 32'd1);
    apb_read(8'h04, rd); check("rx overflow status", rd, exp_status(1'b1));
    while (rx_exp.size() > 0) begin
      apb_read(8'h00, rd); check("rx overflow data", rd, {23'd0, 1'b1, rx_exp.pop_front()});
    end
    apb_write(8'h04, 32'h20); m_rxovf = 1'b0;
    tick(2);
    apb_read(8'h04, rd); check("rxovf cleared", rd, exp_status(1'b1));
    check("irq after rxovf clear", 32'(irq), 32'd0);

    // Framing error: stop bit low discards the byte
    rx_send(8'($urandom), 1'b0, 1'b0, 1'b0);
    m_ferr = 1'b1;
    tick(2);
    apb_read(8'h04, rd); check("frame error status", rd, exp_status(1'b1));
    check("irq frame error", 32'(irq), 32'd1);
    apb_write(8'h04, 32'h40); m_ferr = 1'b0;
    tick(2);
    check("irq frame error cleared", 32'(irq), 32'd0);

    // Random divisor: TX and RX at a different bit time
    w    = int'($urandom_range(4, 13));
    bitp = w + 1;
    apb_write(8'h08, 32'(w));
    b = 8'($urandom);
    apb_write(8'h00, 32'(b));
    tx_capture("tx rand div", b, 1'b0, 1'b0, w);
    b = 8'($urandom);
    rx_send(b, 1'b1, 1'b0, 1'b0);
    tick(2);
    apb_read(8'h00, rd); check("rx rand div", rd, {23'd0, 1'b1, b});
    bitp = 10;
    apb_write(8'h08, 32'd9);
    tick(bitp);

`ifdef CAPE_UART_PARITY_EN
    // Parity: even on 0x01, odd on a random byte, RX parity error
    apb_write(8'h0C, 32'h09);
    apb_write(8'h00, 32'h01);
    tx_capture("tx even par", 8'h01, 1'b1, 1'b1, w);
    apb_write(8'h0C, 32'h19);
    b = 8'($urandom);
    apb_write(8'h00, 32'(b));
    tx_capture("tx odd par", b, 1'b1, ~^b, w);
    tick(bitp);
    apb_write(8'h0C, 32'h09);
    b = 8'($urandom);
    rx_send(b, 1'b1, 1'b1, ~^b);
    rx_exp.push_back(b); m_perr = 1'b1;
    tick(2);
    apb_read(8'h04, rd); check("parity error status", rd, exp_status(1'b1));
    check("irq parity error", 32'(irq), 32'd1);
    apb_read(8'h00, rd); check("parity error byte", rd, {23'd0, 1'b1, rx_exp.pop_front()});
    apb_write(8'h04, 32'h100); m_perr = 1'b0;
    apb_write(8'h0C, 32'h01);
`else
    // Parity controls absent
    apb_write(8'h0C, 32'h1F);
    apb_read(8'h0C, rd); check("ctrl no parity bits", rd, 32'h07);
    apb_write(8'h04, 32'h1FF);
    apb_write(8'h0C, 32'h01);
`endif
    tick(2);
    apb_read(8'h04, rd); check("status before abort", rd, exp_status(1'b1));

    // EN=0 mid-frame aborts transmission
    apb_write(8'h00, 32'h00);
    tick(30);
    check("tx before abort", 32'(txd), 32'd0);
    apb_write(8'h0C, 32'd0);
    tick(1);
    check("tx after abort", 32'(txd), 32'd1);
    check("txd_oe after abort", 32'(txd_oe), 32'd0);
    apb_read(8'h04, rd); check("status after abort", rd, exp_status(1'b1));

    // Reset mid-frame
    apb_write(8'h0C, 32'd1);
    apb_write(8'h00, 32'h00);
    tick(30);
    rst = 1'b1;
    tick(1);
    check("tx mid-frame reset", 32'(txd), 32'd1);
    check("oe mid-frame reset", 32'(txd_oe), 32'd0);
    tick(1);
    rst = 1'b0;
    apb_read(8'h08, rd); check("div after reset", rd, 32'd867);
    apb_read(8'h04, rd); check("status after reset", rd, 32'h01A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
